fruit_spawn_scheduler: RTL and testbench
========================================

// Module: fruit_spawn_scheduler
// PURPOSE
//  Sequences fruit launches for the game. Owns a pool of NUM_SLOTS fruit movers and chooses when to
//  launch a fruit and which free slot receives it. Picks the launch X position and X/Y velocities
//  from an LFSR, and shortens the spawn interval as the cut count rises. Sits between the game FSM
//  (run, cut_count) and the fruit movers (slot_busy in, new_fruit and launch values out).
// PARAMETERS
//  NUM_SLOTS      4        number of fruit movers managed
//  BASE_INTERVAL  60       frames between launches at level 0 (<=255)
//  MIN_INTERVAL   12       floor on the interval (>=2)
//  STEP           4        frames removed from the interval per level
//  LFSR_SEED      16'hACE1 LFSR value after reset (nonzero)
//  X_MIN          64       leftmost launch X
//  X_SPAN_LOG2    9        launch X span = 2**X_SPAN_LOG2 pixels
// PORTS
//  frame_clk    in   1          frame clock; all state on its rising edge
//  Reset_n      in   1          asynchronous reset, active low
//  run          in   1          game active; 0 halts spawning
//  cut_count    in   8          fruits cut so far (unsigned)
//  slot_busy    in   NUM_SLOTS  1 = slot's fruit is in flight
//  new_fruit    out  NUM_SLOTS  one-hot, one-cycle launch strobe
//  launch_x     out  10         launch X position; valid with strobe, held until the next launch
//  launch_vx    out  10         signed (two's complement) X velocity; held
//  launch_vy    out  10         upward speed magnitude; held
//  level        out  4          current difficulty level
//  spawn_count  out  8          total launches since reset; saturates at 255
// BEHAVIOUR
//  Reset (Reset_n=0, async, any state):
//   - state=IDLE; timer=0; new_fruit=0; launch_x/vx/vy=0; level=0; spawn_count=0; lfsr=LFSR_SEED.
//  LFSR:
//   - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle out of reset, in every state.
//   - If the LFSR ever reads 0, load LFSR_SEED.
//  Level and interval:
//   - level = min(cut_count/5, 15); registered on each entry to WAIT.
//   - interval = max(BASE_INTERVAL - STEP*level, MIN_INTERVAL), 8-bit unsigned, no underflow.
//  FSM (Moore; outputs are registered):
//   - IDLE:   run=1 -> WAIT, timer=interval.
//   - WAIT:   timer decrements by 1 per cycle. run=0 -> IDLE (this takes priority);
//             otherwise timer==0 -> PICK.
//   - PICK:   run=0 -> IDLE.
//             Otherwise choose the lowest index i with slot_busy[i]=0, latch i and the launch
//             values, -> LAUNCH. No free slot -> stay in PICK (stall).
//   - LAUNCH: new_fruit = 1<<i for this single cycle only; spawn_count++ (saturating) -> WAIT,
//             timer reloaded. If run=0 in LAUNCH, the strobe still issues, then -> IDLE.
//  Launch values (computed from the LFSR in PICK):
//   - launch_x = X_MIN + lfsr[X_SPAN_LOG2-1:0].
//   - |vx| = lfsr[10:9]+1, range 1..4. Sign is + if launch_x<320, else - (points toward screen centre).
//   - launch_vy = 8 + lfsr[13:11] + level/2.
//  Timing:
//   - First strobe is on the cycle after edge interval+2, counting from the edge that samples run=1.
//   - Steady-state period with a free slot = interval+3 cycles.
//   - Stall in PICK extends the period. After slot_busy[i] falls, the strobe appears within 2 cycles.
//  Slot handoff: a fruit mover raises slot_busy the cycle after its strobe. MIN_INTERVAL>=2
//   guarantees the same slot is not chosen twice.
//  new_fruit is never multi-hot; it is 0 in every state except LAUNCH.
// TESTING
//  1. Defaults, cut_count=0, all slots free, run 0->1:
//     first strobe new_fruit=4'b0001 interval+2=62 cycles later; next strobe 63 cycles after that.
//  2. cut_count=50: level=10, interval=20, period 23 cycles.
//     cut_count=200: level=15, interval=12, period 15 cycles.
//  3. slot_busy=4'b1111 at PICK: no strobe, FSM holds in PICK.
//     Clear bit 2: new_fruit=4'b0100 within 2 cycles; spawn_count increments by 1.
//  4. Reset_n low mid-WAIT: all outputs 0 immediately. After release, the first launch_x and
//     launch_vx match the golden model seeded with 16'hACE1 (reset-to-launch sequence is deterministic).
//  5. run dropped mid-WAIT: no strobe, state IDLE.
//     run dropped while in LAUNCH: exactly one strobe, then IDLE.
//  6. 300 launches: spawn_count holds at 255. Every launch satisfies:
//     64<=launch_x<=575; 1<=|vx|<=4 with sign toward centre; new_fruit always one-hot.

Source files
------------

// File: rtl/fruit_spawn_scheduler.sv
// Launch sequencer for the fruit mover pool: picks a free slot and LFSR-driven launch values each interval.
// Strobe lands interval+2 edges after run is sampled; holds in PICK while every slot is busy.
`timescale 1ns/1ps
module fruit_spawn_scheduler #(
    parameter int          NUM_SLOTS     = 4,
    parameter int          BASE_INTERVAL = 60,
    parameter int          MIN_INTERVAL  = 12,
    parameter int          STEP          = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          X_MIN         = 64,
    parameter int          X_SPAN_LOG2   = 9
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  logic                 run,
    input  logic [7:0]           cut_count,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] new_fruit,
    output logic [9:0]           launch_x,
    output logic [9:0]           launch_vx,
    output logic [9:0]           launch_vy,
    output logic [3:0]           level,
    output logic [7:0]           spawn_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PICK,
        ST_LAUNCH
    } state_t;

    state_t      state;
    logic [7:0]  timer;
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11; free-running so launch values vary with timing
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr == 16'd0) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    logic [7:0]  lvl_div;
    logic [3:0]  level_nxt;
    logic [15:0] step_total;
    logic [7:0]  interval_nxt;

    assign lvl_div    = cut_count / 8'd5;
    assign level_nxt  = (lvl_div > 8'd15) ? 4'd15 : lvl_div[3:0];
    assign step_total = 16'(STEP) * {12'd0, level_nxt};

    // Clamp before subtracting so a high level can never wrap the interval
    always_comb begin
        interval_nxt = 8'(MIN_INTERVAL);
        if (16'(BASE_INTERVAL) >= step_total + 16'(MIN_INTERVAL)) begin
            interval_nxt = 8'(16'(BASE_INTERVAL) - step_total);
        end
    end

    logic [9:0] x_nxt;
    logic [9:0] vx_mag;
    logic [9:0] vx_nxt;
    logic [9:0] vy_nxt;

    assign x_nxt  = 10'(X_MIN) + 10'(lfsr[X_SPAN_LOG2-1:0]);
    assign vx_mag = {8'd0, lfsr[10:9]} + 10'd1;
    assign vx_nxt = (x_nxt < 10'd320) ? vx_mag : (10'd0 - vx_mag);
    assign vy_nxt = 10'd8 + {7'd0, lfsr[13:11]} + {7'd0, level[3:1]};

    logic [NUM_SLOTS-1:0] slot_free;
    logic [NUM_SLOTS-1:0] slot_pick;

    // Isolate the lowest set bit of the free mask: lowest free index, already one-hot
    assign slot_free = ~slot_busy;
    assign slot_pick = slot_free & (~slot_free + NUM_SLOTS'(1));

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            timer       <= 8'd0;
            new_fruit   <= '0;
            launch_x    <= 10'd0;
            launch_vx   <= 10'd0;
            launch_vy   <= 10'd0;
            level       <= 4'd0;
            spawn_count <= 8'd0;
        end else begin
            new_fruit <= '0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_WAIT;
                        timer <= interval_nxt;
                        level <= level_nxt;
                    end
                end
                ST_WAIT: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (timer == 8'd0) begin
                        state <= ST_PICK;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_PICK: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (|slot_free) begin
                        new_fruit <= slot_pick;
                        launch_x  <= x_nxt;
                        launch_vx <= vx_nxt;
                        launch_vy <= vy_nxt;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (spawn_count != 8'hFF) begin
                        spawn_count <= spawn_count + 8'd1;
                    end
                    if (run) begin
                        state <= ST_WAIT;
                        timer <= interval_nxt;
                        level <= level_nxt;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fruit_spawn_scheduler.sv
// Directed bench for fruit_spawn_scheduler with a golden LFSR and a strobe monitor.
`timescale 1ns/1ps
module tb_fruit_spawn_scheduler;

    logic       frame_clk;
    logic       Reset_n;
    logic       run;
    logic [7:0] cut_count;
    logic [3:0] slot_busy;
    logic [3:0] new_fruit;
    logic [9:0] launch_x;
    logic [9:0] launch_vx;
    logic [9:0] launch_vy;
    logic [3:0] level;
    logic [7:0] spawn_count;

    fruit_spawn_scheduler dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .run         (run),
        .cut_count   (cut_count),
        .slot_busy   (slot_busy),
        .new_fruit   (new_fruit),
        .launch_x    (launch_x),
        .launch_vx   (launch_vx),
        .launch_vy   (launch_vy),
        .level       (level),
        .spawn_count (spawn_count)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [3:0] manual_busy;
    logic [3:0] mover_busy;
    logic       mover_en;
    logic       mon_en;
    logic [3:0] exp_lvl;
    assign slot_busy = manual_busy | mover_busy;

    // Golden LFSR: m_prev is the value the DUT used at the most recent edge
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic [3:0]  samp_busy;

    always @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            if (m_lfsr == 16'd0) m_lfsr <= 16'hACE1;
            else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(posedge frame_clk) samp_busy <= slot_busy;

    function automatic logic [3:0] lowest_free(input logic [3:0] b);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 3; i >= 0; i--) if (!b[i]) r = 4'b0001 << i;
        return r;
    endfunction

    int         flight [4];
    logic       last_strobe;
    logic [9:0] e_x;
    logic [9:0] e_mag;
    logic [9:0] e_vx;
    logic [9:0] e_vy;

    initial begin
        for (int i = 0; i < 4; i++) flight[i] = 0;
        mover_busy  = 4'b0000;
        last_strobe = 1'b0;
    end

    // Strobe monitor plus a simple fruit-mover model with a fixed flight time
    always @(negedge frame_clk) begin
        if (Reset_n && mon_en && new_fruit != 4'b0000) begin
            e_x   = 10'd64 + {1'b0, m_prev[8:0]};
            e_mag = {8'd0, m_prev[10:9]} + 10'd1;
            e_vx  = (e_x < 10'd320) ? e_mag : (10'd0 - e_mag);
            e_vy  = 10'd8 + {7'd0, m_prev[13:11]} + {7'd0, exp_lvl[3:1]};
            check_val("m_onehot", {31'd0, $onehot(new_fruit)}, 32'd1);
            check_val("m_slot", {28'd0, new_fruit}, {28'd0, lowest_free(samp_busy)});
            check_val("m_1cyc", {31'd0, last_strobe}, 32'd0);
            check_val("m_x", {22'd0, launch_x}, {22'd0, e_x});
            check_val("m_x_range", {31'd0, (launch_x >= 10'd64 && launch_x <= 10'd575)}, 32'd1);
            check_val("m_vx", {22'd0, launch_vx}, {22'd0, e_vx});
            check_val("m_vy", {22'd0, launch_vy}, {22'd0, e_vy});
        end
        last_strobe = (new_fruit != 4'b0000);
        for (int i = 0; i < 4; i++) begin
            if (mover_en && new_fruit[i]) flight[i] = 40;
            else if (flight[i] != 0) flight[i] = flight[i] - 1;
            mover_busy[i] = (flight[i] != 0);
        end
    end

    task automatic wait_strobe(input string tag, input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge frame_clk);
            n++;
            @(negedge frame_clk);
        end while (new_fruit == 4'b0000 && n < max_cyc);
        check_val({tag, "_seen"}, {31'd0, new_fruit != 4'b0000}, 32'd1);
    endtask

    task automatic no_strobe(input string tag, input int cyc);
        int cnt = 0;
        for (int k = 0; k < cyc; k++) begin
            @(posedge frame_clk);
            @(negedge frame_clk);
            if (new_fruit != 4'b0000) cnt++;
        end
        check_val(tag, cnt, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset_n     = 1'b0;
        run         = 1'b0;
        cut_count   = 8'd0;
        manual_busy = 4'b0000;
        mover_en    = 1'b0;
        mon_en      = 1'b0;
        exp_lvl     = 4'd0;
        repeat (3) @(negedge frame_clk);
        check_val("rst_new_fruit", {28'd0, new_fruit}, 32'd0);
        check_val("rst_x", {22'd0, launch_x}, 32'd0);
        check_val("rst_vx", {22'd0, launch_vx}, 32'd0);
        check_val("rst_vy", {22'd0, launch_vy}, 32'd0);
        check_val("rst_level", {28'd0, level}, 32'd0);
        check_val("rst_spawn", {24'd0, spawn_count}, 32'd0);
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (2) @(negedge frame_clk);

        // Default interval: first strobe 62 edges after run sampled, then every 63
        run = 1'b1;
        wait_strobe("t1_first", 100, n);
        check_val("t1_first_lat", n - 1, 32'd62);
        check_val("t1_first_slot", {28'd0, new_fruit}, 32'd1);
        wait_strobe("t1_next", 100, n);
        check_val("t1_period", n, 32'd63);
        check_val("t1_next_slot", {28'd0, new_fruit}, 32'd1);
        run = 1'b0;
        no_strobe("t5_launch_drop", 100);
        check_val("t1_spawn", {24'd0, spawn_count}, 32'd2);
        check_val("t1_level", {28'd0, level}, 32'd0);

        // Level 10: interval 20
        cut_count = 8'd50;
        exp_lvl   = 4'd10;
        run = 1'b1;
        wait_strobe("t2a_first", 100, n);
        check_val("t2a_first_lat", n - 1, 32'd22);
        check_val("t2a_level", {28'd0, level}, 32'd10);
        wait_strobe("t2a_next", 100, n);
        check_val("t2a_period", n, 32'd23);
        run = 1'b0;
        repeat (5) @(negedge frame_clk);

        // Level saturates at 15: interval floors at 12
        cut_count = 8'd200;
        exp_lvl   = 4'd15;
        run = 1'b1;
        wait_strobe("t2b_first", 100, n);
        check_val("t2b_first_lat", n - 1, 32'd14);
        check_val("t2b_level", {28'd0, level}, 32'd15);
        wait_strobe("t2b_next", 100, n);
        check_val("t2b_period", n, 32'd15);
        run = 1'b0;
        repeat (5) @(negedge frame_clk);
        check_val("t2_spawn", {24'd0, spawn_count}, 32'd6);

        // run dropped mid-WAIT
        cut_count = 8'd0;
        exp_lvl   = 4'd0;
        run = 1'b1;
        repeat (20) @(negedge frame_clk);
        run = 1'b0;
        no_strobe("t5_wait_drop", 100);
        check_val("t5_level", {28'd0, level}, 32'd0);

        // All slots busy: stall in PICK, release slot 2
        manual_busy = 4'b1111;
        run = 1'b1;
        no_strobe("t3_stall", 100);
        manual_busy = 4'b1011;
        wait_strobe("t3_release", 3, n);
        check_val("t3_release_lat", {31'd0, n <= 2}, 32'd1);
        check_val("t3_slot", {28'd0, new_fruit}, 32'd4);
        run = 1'b0;
        manual_busy = 4'b0000;
        repeat (3) @(negedge frame_clk);
        check_val("t3_spawn", {24'd0, spawn_count}, 32'd7);

        // Async reset mid-WAIT clears outputs at once; replay from seed
        cut_count = 8'd50;
        exp_lvl   = 4'd10;
        run = 1'b1;
        repeat (30) @(negedge frame_clk);
        Reset_n = 1'b0;
        #1;
        check_val("t4_new_fruit", {28'd0, new_fruit}, 32'd0);
        check_val("t4_x", {22'd0, launch_x}, 32'd0);
        check_val("t4_vx", {22'd0, launch_vx}, 32'd0);
        check_val("t4_vy", {22'd0, launch_vy}, 32'd0);
        check_val("t4_level", {28'd0, level}, 32'd0);
        check_val("t4_spawn", {24'd0, spawn_count}, 32'd0);
        @(negedge frame_clk);
        Reset_n = 1'b1;
        wait_strobe("t4_first", 100, n);
        check_val("t4_first_lat", n - 1, 32'd22);
        run = 1'b0;
        repeat (3) @(negedge frame_clk);
        check_val("t4_spawn_after", {24'd0, spawn_count}, 32'd1);

        // 300 launches with movers occupying slots: counter saturates
        cut_count = 8'd200;
        exp_lvl   = 4'd15;
        mover_en  = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 300; k++) wait_strobe("t6", 60, n);
        run = 1'b0;
        repeat (3) @(negedge frame_clk);
        check_val("t6_spawn_sat", {24'd0, spawn_count}, 32'd255);
        mover_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
